// File: rtl/fmap_out_packer_if.sv
// Handshake bundle between the PE bit stream, the packer and the next-layer consumer.
// slave is the packer side; master is whatever drives the PE bits and consumes words.
interface fmap_out_packer_if #(
  parameter int W = 512
);
  logic         pe_valid;
  logic         pe_bit;
  logic         pe_stall;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         frame_done;
  logic         err_overrun;

  modport slave (
    input  pe_valid, pe_bit, out_ready,
    output pe_stall, out_data, out_valid, out_last, frame_done, err_overrun
  );

  modport master (
    output pe_valid, pe_bit, out_ready,
    input  pe_stall, out_data, out_valid, out_last, frame_done, err_overrun
  );
endinterface

// File: rtl/fmap_out_packer.sv
// Packs serial PE output bits into W-bit fmap words, tags the frame's last pixel and
// queues the words in a small show-ahead FIFO feeding a valid/ready port.
module fmap_out_packer #(
  parameter int FD         = 512,
  parameter int N_PE       = 1,
  parameter int FIFO_DEPTH = 2,
  parameter int FMAP_W     = 32,
  parameter int FMAP_H     = 32
) (
  input logic              clk,
  input logic              rst,
  fmap_out_packer_if.slave io
);
  localparam int W  = FD / N_PE;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int XW = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
  localparam int YW = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } word_t;

  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_nxt;
  logic [CW-1:0] bitcnt;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  word_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          accept, push, pop, tag_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stall depends only on the registered count, so out_ready never reaches pe_stall.
  assign io.pe_stall  = (count == NW'(FIFO_DEPTH));
  assign io.out_valid = (count != '0);
  assign io.out_data  = mem[rd_ptr].data;
  assign io.out_last  = mem[rd_ptr].last;

  assign accept    = io.pe_valid & ~io.pe_stall;
  assign push      = accept && (bitcnt == CW'(W - 1));
  assign pop       = io.out_valid & io.out_ready;
  assign shreg_nxt = {io.pe_bit, shreg[W-1:1]};
  assign tag_last  = (col == XW'(FMAP_W - 1)) && (row == YW'(FMAP_H - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg          <= '0;
      bitcnt         <= '0;
      col            <= '0;
      row            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io.err_overrun <= 1'b0;
      io.frame_done  <= 1'b0;
    end else begin
      if (accept) begin
        shreg  <= shreg_nxt;
        bitcnt <= push ? '0 : bitcnt + 1'b1;
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        if (tag_last) begin
          col <= '0;
          row <= '0;
        end else if (col == XW'(FMAP_W - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A bit offered while stalled is lost; flag it until the next reset.
      if (io.pe_valid && io.pe_stall) io.err_overrun <= 1'b1;
      io.frame_done <= pop & io.out_last;
    end
  end

  // Storage needs no reset: count gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: tag_last, data: shreg_nxt};
  end
endmodule

// File: tb/tb_fmap_out_packer.sv
// Randomized + directed bench for fmap_out_packer against a queue-based reference model.
module tb_fmap_out_packer;
  localparam int FD    = 16;
  localparam int N_PE  = 2;
  localparam int W     = FD / N_PE;
  localparam int DEPTH = 2;
  localparam int FW    = 2;
  localparam int FH    = 2;
  localparam int NPIX  = FW * FH;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fmap_out_packer_if #(.W(W)) io ();

  fmap_out_packer #(
    .FD(FD), .N_PE(N_PE), .FIFO_DEPTH(DEPTH), .FMAP_W(FW), .FMAP_H(FH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;

  ent_t         m_q[$];
  logic [W-1:0] m_word;
  int           m_nbits;
  int           m_pix;
  logic         m_err;
  logic         m_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(io.out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_data", 32'(io.out_data), 32'(m_q[0].data));
      check("out_last", 32'(io.out_last), 32'(m_q[0].last));
    end
    check("pe_stall", 32'(io.pe_stall), 32'(m_q.size() == DEPTH));
    check("frame_done", 32'(io.frame_done), 32'(m_fd));
    check("err_overrun", 32'(io.err_overrun), 32'(m_err));
    if (io.frame_done) fd_cnt++;
  endtask

  // Called at a negedge: check current outputs, apply inputs, advance the model one clock.
  task automatic cycle(input logic v, input logic b, input logic rdy);
    logic stall, pop;
    io.pe_valid  = v;
    io.pe_bit    = b;
    io.out_ready = rdy;
    compare_all();
    stall = (m_q.size() == DEPTH);
    pop   = (m_q.size() != 0) && rdy;
    m_fd  = pop && m_q[0].last;
    if (v && stall) m_err = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (v && !stall) begin
      m_word[m_nbits] = b;
      m_nbits++;
      if (m_nbits == W) begin
        m_q.push_back('{data: m_word, last: (m_pix == NPIX - 1)});
        m_pix   = (m_pix + 1) % NPIX;
        m_nbits = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    io.pe_valid  = 1'b0;
    io.pe_bit    = 1'b0;
    io.out_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_q.delete();
    m_word  = '0;
    m_nbits = 0;
    m_pix   = 0;
    m_err   = 1'b0;
    m_fd    = 1'b0;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] val, input logic rdy);
    for (int i = 0; i < 8; i++) cycle(1'b1, val[i], rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rdy);
  endtask

  initial begin
    logic [7:0] y;
    io.pe_valid  = 1'b0;
    io.pe_bit    = 1'b0;
    io.out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_valid", 32'(io.out_valid), 32'd0);
    check("reset_stall", 32'(io.pe_stall), 32'd0);

    // 1: single word, 1-clk latency
    send_byte(8'h4D, 1'b1);
    check("t1_valid", 32'(io.out_valid), 32'd1);
    check("t1_data", 32'(io.out_data), 32'h4D);
    idle(2, 1'b1);

    // 2: fill FIFO, overrun, drain
    do_reset();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b0);
    check("t2_stall", 32'(io.pe_stall), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    check("t2_err", 32'(io.err_overrun), 32'd1);
    check("t2_head", 32'(io.out_data), 32'hFF);
    cycle(1'b0, 1'b0, 1'b1);
    check("t2_stall_drop", 32'(io.pe_stall), 32'd0);
    check("t2_second", 32'(io.out_data), 32'h01);
    idle(2, 1'b1);

    // 3: frame tagging over a 2x2 fmap
    do_reset();
    fd_cnt = 0;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
    idle(3, 1'b1);
    check("t3_fd_pulses", 32'(fd_cnt), 32'd1);

    // 4: reset discards a partial word
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1);
    do_reset();
    send_byte(8'h00, 1'b0);
    check("t4_data", 32'(io.out_data), 32'h00);
    check("t4_last", 32'(io.out_last), 32'd0);
    idle(2, 1'b1);

    // 5: push and pop in the same cycle with one word queued
    do_reset();
    send_byte(8'h5A, 1'b0);
    y = 8'hC3;
    for (int i = 0; i < 7; i++) cycle(1'b1, y[i], 1'b0);
    cycle(1'b1, y[7], 1'b1);
    check("t5_valid", 32'(io.out_valid), 32'd1);
    check("t5_data", 32'(io.out_data), 32'hC3);
    check("t5_stall", 32'(io.pe_stall), 32'd0);
    idle(2, 1'b1);

    // 6: W = FD/N_PE = 8, two back-to-back words
    do_reset();
    send_byte(8'hA5, 1'b1);
    check("t6_first", 32'(io.out_data), 32'hA5);
    send_byte(8'h3C, 1'b1);
    check("t6_second", 32'(io.out_data), 32'h3C);
    idle(2, 1'b1);

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
